// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters and system_ram.
// slave  : arbiter side (takes requests and mem_q, drives acks, rdata and RAM pins)
// master : environment side (requesters plus the RAM)
interface mem_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [31:0]       p0_wdata;
   logic [3:0]        p0_be;
   logic              p0_ack;
   logic [31:0]       p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [31:0]       p1_wdata;
   logic [3:0]        p1_be;
   logic              p1_ack;
   logic [31:0]       p1_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic [3:0]        mem_byteena;
   logic              mem_wren;
   logic              mem_rden;
   logic [31:0]       mem_q;

   logic              grant_id;
   logic              busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      input  mem_q,
      output p0_ack, p0_rdata, p1_ack, p1_rdata,
      output mem_addr, mem_data, mem_byteena, mem_wren, mem_rden,
      output grant_id, busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
      output mem_q,
      input  p0_ack, p0_rdata, p1_ack, p1_rdata,
      input  mem_addr, mem_data, mem_byteena, mem_wren, mem_rden,
      input  grant_id, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported system_ram.
// Port 0 = instruction fetch, port 1 = load/store. Accesses are serialised
// and completed with a one-cycle ack; reads return after RD_LAT cycles.
// Optional feature: define MEM_ARB_RR_EN for round-robin on contention;
// otherwise port 1 always wins contention.
//
// state | meaning
// IDLE  | no access in progress; pick a winner and latch its fields
// ISSUE | drive RAM address/data and one strobe for a single cycle
// WAIT  | count down read latency, capture mem_q at terminal count
// DONE  | pulse the winner's ack; requests are ignored here
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

   state_t            state;
   state_t            state_nxt;

   logic              grant_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_be;
   logic [1:0]        cnt;
   logic [31:0]       rdata0;
   logic [31:0]       rdata1;

   logic              any_req;
   logic              sel_id;
   logic              wren;
   logic              rden;
   logic              ack0;
   logic              ack1;

`ifdef MEM_ARB_RR_EN
   // port served most recently; reset value 1 hands the first contention to port 0
   logic              last_id;
`endif

   // winner selection among the current requesters
   always_comb begin
      any_req = bus.p0_req | bus.p1_req;
      sel_id  = bus.p1_req;
      if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_RR_EN
         sel_id = ~last_id;
`else
         sel_id = 1'b1;
`endif
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state and RAM strobe / ack decode
   always_comb begin
      state_nxt = state;
      wren      = 1'b0;
      rden      = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (any_req) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            wren      = lat_we;
            rden      = ~lat_we;
            state_nxt = lat_we ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (cnt == 2'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            ack0      = ~grant_id;
            ack1      = grant_id;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // request latch, latency timer and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id  <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         cnt       <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
`ifdef MEM_ARB_RR_EN
         last_id   <= 1'b1;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_id  <= sel_id;
                  lat_we    <= sel_id ? bus.p1_we    : bus.p0_we;
                  lat_addr  <= sel_id ? bus.p1_addr  : bus.p0_addr;
                  lat_wdata <= sel_id ? bus.p1_wdata : bus.p0_wdata;
                  lat_be    <= sel_id ? bus.p1_be    : bus.p0_be;
`ifdef MEM_ARB_RR_EN
                  last_id   <= sel_id;
`endif
               end
            end
            S_ISSUE: begin
               cnt <= CNT_LOAD;
            end
            S_WAIT: begin
               if (cnt == 2'd0) begin
                  if (grant_id) rdata1 <= bus.mem_q;
                  else          rdata0 <= bus.mem_q;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // latched fields are presented continuously; only the strobes qualify them
   assign bus.mem_addr    = lat_addr;
   assign bus.mem_data    = lat_wdata;
   assign bus.mem_byteena = lat_be;
   assign bus.mem_wren    = wren;
   assign bus.mem_rden    = rden;
   assign bus.p0_ack      = ack0;
   assign bus.p1_ack      = ack1;
   assign bus.p0_rdata    = rdata0;
   assign bus.p1_rdata    = rdata1;
   assign bus.grant_id    = grant_id;
   assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance a (RD_LAT=1) and instance b (RD_LAT=3),
// each backed by a small byte-enabled RAM model with matching read latency.
module tb_mem_arbiter;
   localparam int ADDR_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) ifa ();
   mem_arbiter_if #(.ADDR_W(ADDR_W)) ifb ();

   mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // RAM models: preload on reset, byte-enabled writes, read pipeline of depth RD_LAT
   logic [31:0] mem_a  [0:255];
   logic [31:0] pipe_a [0:3];
   logic [31:0] mem_b  [0:255];
   logic [31:0] pipe_b [0:3];

   always @(posedge clk) begin
      if (rst) begin
         mem_a[8'h10] <= 32'h00500093;
         mem_a[8'h20] <= 32'h00000000;
         mem_a[8'h30] <= 32'h11110030;
         mem_a[8'h31] <= 32'h11110031;
         mem_a[8'h40] <= 32'h22220040;
         mem_a[8'h41] <= 32'h22220041;
      end else if (ifa.mem_wren) begin
         for (int b = 0; b < 4; b++)
            if (ifa.mem_byteena[b]) mem_a[ifa.mem_addr[7:0]][8*b +: 8] <= ifa.mem_data[8*b +: 8];
      end
      pipe_a[0] <= ifa.mem_rden ? mem_a[ifa.mem_addr[7:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
   end

   always @(posedge clk) begin
      if (rst) begin
         mem_b[8'h10] <= 32'h00500093;
         mem_b[8'h14] <= 32'hCAFEF00D;
      end else if (ifb.mem_wren) begin
         for (int b = 0; b < 4; b++)
            if (ifb.mem_byteena[b]) mem_b[ifb.mem_addr[7:0]][8*b +: 8] <= ifb.mem_data[8*b +: 8];
      end
      pipe_b[0] <= ifb.mem_rden ? mem_b[ifb.mem_addr[7:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
   end

   assign ifa.mem_q = pipe_a[0];
   assign ifb.mem_q = pipe_b[2];

   // scoreboard pop on every ack
   task automatic on_ack(input int inst, input logic a0, input logic a1, input logic g,
                         input logic [31:0] r0, input logic [31:0] r1);
      exp_t e;
      int   port;
      port = a1 ? 1 : 0;
      chk("ack_one_hot", 32'(a0 & a1), 0);
      if ((inst == 0 && sb_a.size() == 0) || (inst == 1 && sb_b.size() == 0)) begin
         chk("unexpected_ack", 32'(port), 32'hFFFFFFFF);
      end else begin
         e = (inst == 0) ? sb_a.pop_front() : sb_b.pop_front();
         chk("ack_port", 32'(port), 32'(e.port));
         chk("ack_grant_id", 32'(g), 32'(e.port));
         if (!e.we) chk("ack_rdata", port == 1 ? r1 : r0, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (ifa.p0_ack || ifa.p1_ack)
         on_ack(0, ifa.p0_ack, ifa.p1_ack, ifa.grant_id, ifa.p0_rdata, ifa.p1_rdata);
      if (ifb.p0_ack || ifb.p1_ack)
         on_ack(1, ifb.p0_ack, ifb.p1_ack, ifb.grant_id, ifb.p0_rdata, ifb.p1_rdata);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // returns at the negedge where the ack is seen, or after budget cycles
   task automatic wait_ack(input int inst, input int port, input int budget);
      bit ok;
      logic a;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (inst == 0) a = (port == 0) ? ifa.p0_ack : ifa.p1_ack;
         else           a = (port == 0) ? ifb.p0_ack : ifb.p1_ack;
         if (a) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ack_timeout", 32'(ok), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [4];
      int c0;
      int c1;
      exp_t e;

      ifa.p0_req = 0; ifa.p0_we = 0; ifa.p0_addr = '0; ifa.p0_wdata = '0; ifa.p0_be = '0;
      ifa.p1_req = 0; ifa.p1_we = 0; ifa.p1_addr = '0; ifa.p1_wdata = '0; ifa.p1_be = '0;
      ifb.p0_req = 0; ifb.p0_we = 0; ifb.p0_addr = '0; ifb.p0_wdata = '0; ifb.p0_be = '0;
      ifb.p1_req = 0; ifb.p1_we = 0; ifb.p1_addr = '0; ifb.p1_wdata = '0; ifb.p1_be = '0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_ctrl", 32'({ifa.busy, ifa.p0_ack, ifa.p1_ack, ifa.mem_wren, ifa.mem_rden, ifa.grant_id}), 0);
         chk("idle_rdata", ifa.p0_rdata | ifa.p1_rdata, 0);
         chk("idle_mem_addr", 32'(ifa.mem_addr), 0);
      end

      // p0 read, RD_LAT=1
      sb_a.push_back('{0, 1'b0, 32'h00500093});
      ifa.p0_req = 1; ifa.p0_we = 0; ifa.p0_addr = 16'h0010; ifa.p0_be = 4'hF;
      step();
      chk("rd_issue_rden", 32'(ifa.mem_rden), 1);
      chk("rd_issue_wren", 32'(ifa.mem_wren), 0);
      chk("rd_issue_addr", 32'(ifa.mem_addr), 32'h10);
      step();
      chk("rd_wait_rden", 32'(ifa.mem_rden), 0);
      chk("rd_wait_ack", 32'(ifa.p0_ack), 0);
      chk("rd_wait_busy", 32'(ifa.busy), 1);
      step();
      chk("rd_ack_t3", 32'(ifa.p0_ack), 1);
      ifa.p0_req = 0;
      step();
      chk("rd_idle_busy", 32'(ifa.busy), 0);
      chk("rd_rdata_hold", ifa.p0_rdata, 32'h00500093);

      // p1 write 0xDEADBEEF to 0x20 with be=0011
      sb_a.push_back('{1, 1'b1, 32'h0});
      ifa.p1_req = 1; ifa.p1_we = 1; ifa.p1_addr = 16'h0020;
      ifa.p1_wdata = 32'hDEADBEEF; ifa.p1_be = 4'b0011;
      step();
      chk("wr_issue_wren", 32'(ifa.mem_wren), 1);
      chk("wr_issue_rden", 32'(ifa.mem_rden), 0);
      chk("wr_issue_be", 32'(ifa.mem_byteena), 32'h3);
      chk("wr_issue_data", ifa.mem_data, 32'hDEADBEEF);
      chk("wr_issue_addr", 32'(ifa.mem_addr), 32'h20);
      chk("wr_grant", 32'(ifa.grant_id), 1);
      step();
      chk("wr_ack_t2", 32'(ifa.p1_ack), 1);
      chk("wr_p0_ack", 32'(ifa.p0_ack), 0);
      chk("wr_done_wren", 32'(ifa.mem_wren), 0);
      ifa.p1_req = 0;
      step();
      chk("wr_ram", mem_a[8'h20], 32'h0000BEEF);

      // p1 read-back of the partial write
      sb_a.push_back('{1, 1'b0, 32'h0000BEEF});
      ifa.p1_req = 1; ifa.p1_we = 0; ifa.p1_addr = 16'h0020;
      wait_ack(0, 1, 20);
      step();
      ifa.p1_req = 0;
      chk("rb_p1_rdata", ifa.p1_rdata, 32'h0000BEEF);
      chk("rb_p0_rdata_hold", ifa.p0_rdata, 32'h00500093);
      step();

      // contention: both ports issue two reads each, req held continuously
`ifdef MEM_ARB_RR_EN
      order = '{0, 1, 0, 1};
`else
      order = '{1, 1, 0, 0};
`endif
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 4; i++) begin
         e.port = order[i];
         e.we   = 1'b0;
         if (order[i] == 0) begin
            e.data = mem_a[8'h30 + 8'(c0)];
            c0++;
         end else begin
            e.data = mem_a[8'h40 + 8'(c1)];
            c1++;
         end
         sb_a.push_back(e);
      end
      fork
         begin
            for (int k = 0; k < 2; k++) begin
               ifa.p0_req = 1; ifa.p0_we = 0; ifa.p0_addr = 16'h0030 + 16'(k);
               wait_ack(0, 0, 40);
               @(posedge clk);
               #1;
            end
            ifa.p0_req = 0;
         end
         begin
            for (int k = 0; k < 2; k++) begin
               ifa.p1_req = 1; ifa.p1_we = 0; ifa.p1_addr = 16'h0040 + 16'(k);
               wait_ack(0, 1, 40);
               @(posedge clk);
               #1;
            end
            ifa.p1_req = 0;
         end
      join
      step();
      chk("cont_idle", 32'(ifa.busy), 0);

      // instance b (RD_LAT=3): one full read, then reset during WAIT
      sb_b.push_back('{0, 1'b0, 32'hCAFEF00D});
      ifb.p0_req = 1; ifb.p0_we = 0; ifb.p0_addr = 16'h0014; ifb.p0_be = 4'hF;
      wait_ack(1, 0, 20);
      step();
      ifb.p0_req = 0;
      chk("b_rdata_pre", ifb.p0_rdata, 32'hCAFEF00D);
      step();
      ifb.p0_req = 1; ifb.p0_addr = 16'h0010;
      step();
      chk("b_issue_rden", 32'(ifb.mem_rden), 1);
      step();
      chk("b_wait_busy", 32'(ifb.busy), 1);
      rst = 1'b1;
      step();
      chk("b_rst_busy", 32'(ifb.busy), 0);
      chk("b_rst_ack", 32'(ifb.p0_ack | ifb.p1_ack), 0);
      chk("b_rst_rdata", ifb.p0_rdata, 0);
      chk("b_rst_strobes", 32'(ifb.mem_rden | ifb.mem_wren), 0);
      ifb.p0_req = 0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("b_post_rst_ack", 32'(ifb.p0_ack), 0);
      end
      sb_b.push_back('{0, 1'b0, 32'h00500093});
      ifb.p0_req = 1; ifb.p0_addr = 16'h0010;
      wait_ack(1, 0, 20);
      step();
      ifb.p0_req = 0;
      chk("b_rdata_after", ifb.p0_rdata, 32'h00500093);
      repeat (3) step();

      chk("sb_a_empty", 32'(sb_a.size()), 0);
      chk("sb_b_empty", 32'(sb_b.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
